// File: rtl/player_anim_sequencer_if.sv
// Player state flags in, animation selection out; the sequencer sits on the slave side.
interface player_anim_sequencer_if;
    logic [1:0] gameState;
    logic       moving;
    logic       jumping;
    logic       aimUp;
    logic       aimDown;
    logic       dead;
    logic       Direction;
    logic [2:0] animSel;
    logic [2:0] frameIdx;
    logic       faceLeft;
    logic       animChange;
    logic       deathDone;

    modport master (
        output gameState, moving, jumping, aimUp, aimDown, dead, Direction,
        input  animSel, frameIdx, faceLeft, animChange, deathDone
    );

    modport slave (
        input  gameState, moving, jumping, aimUp, aimDown, dead, Direction,
        output animSel, frameIdx, faceLeft, animChange, deathDone
    );
endinterface

// File: rtl/player_anim_sequencer.sv
// Picks the active player animation and steps its frame index once per FRAME_DIV frame ticks.
module player_anim_sequencer #(
    parameter int unsigned FRAME_DIV   = 6,
    parameter int unsigned RUN_FRAMES  = 6,
    parameter int unsigned RL_FRAMES   = 3,
    parameter int unsigned JUMP_FRAMES = 4,
    parameter int unsigned DEAD_FRAMES = 5
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_clk,
    player_anim_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        ANIM_WAIT    = 3'd0,
        ANIM_RUN     = 3'd1,
        ANIM_JUMP    = 3'd2,
        ANIM_UP      = 3'd3,
        ANIM_DOWN    = 3'd4,
        ANIM_UP_RL   = 3'd5,
        ANIM_DOWN_RL = 3'd6,
        ANIM_DEAD    = 3'd7
    } anim_e;

    localparam logic [5:0] DIV_LAST  = 6'(FRAME_DIV - 1);
    localparam logic [2:0] DEAD_LAST = 3'(DEAD_FRAMES - 1);

    anim_e      state_q, state_d;
    logic [2:0] frame_q, frame_d;
    logic [5:0] div_q, div_d;
    logic       face_q, face_d;
    logic       chg_q, chg_d;
    logic       done_q, done_d;
    logic       frame_clk_q;
    logic       tick;
    logic       playing;
    anim_e      target;

    // Looping animations wrap, DEAD saturates on its last frame, single-frame ones stay at 0.
    function automatic logic [2:0] next_frame(anim_e a, logic [2:0] f);
        logic [2:0] last;
        logic [2:0] nf;
        nf = 3'd0;
        case (a)
            ANIM_RUN:                last = 3'(RUN_FRAMES - 1);
            ANIM_JUMP:               last = 3'(JUMP_FRAMES - 1);
            ANIM_UP_RL, ANIM_DOWN_RL: last = 3'(RL_FRAMES - 1);
            ANIM_DEAD:               last = DEAD_LAST;
            default:                 last = 3'd0;
        endcase
        if (a == ANIM_DEAD) begin
            nf = (f >= last) ? last : f + 3'd1;
        end else begin
            nf = (f >= last) ? 3'd0 : f + 3'd1;
        end
        return nf;
    endfunction

    function automatic anim_e pick_anim(logic dd, logic jp, logic mv, logic up, logic dn);
        anim_e a;
        if (dd)            a = ANIM_DEAD;
        else if (jp)       a = ANIM_JUMP;
        else if (mv && up) a = ANIM_UP_RL;
        else if (mv && dn) a = ANIM_DOWN_RL;
        else if (mv)       a = ANIM_RUN;
        else if (up)       a = ANIM_UP;
        else if (dn)       a = ANIM_DOWN;
        else               a = ANIM_WAIT;
        return a;
    endfunction

    assign tick    = frame_clk & ~frame_clk_q;
    assign playing = (bus.gameState == 2'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ANIM_WAIT;
            frame_q     <= 3'd0;
            div_q       <= 6'd0;
            face_q      <= 1'b0;
            chg_q       <= 1'b0;
            done_q      <= 1'b0;
            frame_clk_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            div_q       <= div_d;
            face_q      <= face_d;
            chg_q       <= chg_d;
            done_q      <= done_d;
            frame_clk_q <= frame_clk;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        face_d  = face_q;
        chg_d   = 1'b0;
        done_d  = 1'b0;
        target  = state_q;

        if (tick && state_q != ANIM_DEAD) begin
            face_d = bus.Direction;
        end

        // Leaving PLAY forces WAIT every cycle, independent of ticks and of DEAD.
        if (!playing) begin
            state_d = ANIM_WAIT;
            frame_d = 3'd0;
            div_d   = 6'd0;
            chg_d   = (state_q != ANIM_WAIT);
        end else if (tick) begin
            if (state_q == ANIM_DEAD) begin
                target = ANIM_DEAD;
            end else begin
                target = pick_anim(bus.dead, bus.jumping, bus.moving, bus.aimUp, bus.aimDown);
            end

            if (target != state_q) begin
                state_d = target;
                frame_d = 3'd0;
                div_d   = 6'd0;
                chg_d   = 1'b1;
                done_d  = (target == ANIM_DEAD) && (DEAD_FRAMES == 1);
            end else if (div_q == DIV_LAST) begin
                div_d   = 6'd0;
                frame_d = next_frame(state_q, frame_q);
                done_d  = (state_q == ANIM_DEAD) && (frame_q != DEAD_LAST) && (frame_d == DEAD_LAST);
            end else begin
                div_d = div_q + 6'd1;
            end
        end
    end

    assign bus.animSel    = state_q;
    assign bus.frameIdx   = frame_q;
    assign bus.faceLeft   = face_q;
    assign bus.animChange = chg_q;
    assign bus.deathDone  = done_q;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Bench for player_anim_sequencer: priority table plus hand-written multi-tick sequences.
module tb_player_anim_sequencer;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    player_anim_sequencer_if u_if ();

    player_anim_sequencer #(
        .FRAME_DIV  (6),
        .RUN_FRAMES (6),
        .RL_FRAMES  (3),
        .JUMP_FRAMES(4),
        .DEAD_FRAMES(5)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .bus      (u_if)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] anim;
        logic [2:0] frame;
        logic       face;
        logic       chg;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic [1:0] gs;
        logic       mv;
        logic       jp;
        logic       up;
        logic       dn;
        logic       dd;
        logic       dir;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(logic [2:0] a, logic [2:0] f, logic fc, logic c, logic d);
        exp_t e;
        e.anim = a; e.frame = f; e.face = fc; e.chg = c; e.done = d;
        return e;
    endfunction

    task automatic set_in(input logic [1:0] gs, input logic mv, input logic jp, input logic up,
                          input logic dn, input logic dd, input logic dir);
        u_if.gameState = gs;
        u_if.moving    = mv;
        u_if.jumping   = jp;
        u_if.aimUp     = up;
        u_if.aimDown   = dn;
        u_if.dead      = dd;
        u_if.Direction = dir;
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        exp_t a;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty when output sampled", nm);
            return;
        end
        e = exp_q.pop_front();
        a = mk(u_if.animSel, u_if.frameIdx, u_if.faceLeft, u_if.animChange, u_if.deathDone);
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got anim=%0d frame=%0d face=%b chg=%b done=%b, expected anim=%0d frame=%0d face=%b chg=%b done=%b",
                     nm, a.anim, a.frame, a.face, a.chg, a.done, e.anim, e.frame, e.face, e.chg, e.done);
        end
    endtask

    // One tick: frame_clk high for one Clk, then low for one Clk; pulses must be one cycle wide.
    task automatic do_tick(input string nm, input exp_t e);
        exp_q.push_back(e);
        @(negedge Clk); frame_clk = 1'b1;
        @(posedge Clk); #1; check_out(nm);
        @(negedge Clk); frame_clk = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (u_if.animChange !== 1'b0 || u_if.deathDone !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_width: got chg=%b done=%b, expected chg=0 done=0",
                     nm, u_if.animChange, u_if.deathDone);
        end
    endtask

    task automatic expect_cycle(input string nm, input exp_t e);
        exp_q.push_back(e);
        @(posedge Clk); #1; check_out(nm);
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Priority table, entered from RUN with Direction=0.
        tbl[0] = '{gs:2'd1, mv:1, jp:1, up:1, dn:0, dd:0, dir:0, e:mk(3'd2, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[1] = '{gs:2'd1, mv:1, jp:0, up:1, dn:0, dd:0, dir:0, e:mk(3'd5, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[2] = '{gs:2'd1, mv:1, jp:0, up:1, dn:1, dd:0, dir:0, e:mk(3'd5, 3'd0, 1'b0, 1'b0, 1'b0)};
        tbl[3] = '{gs:2'd1, mv:1, jp:0, up:0, dn:1, dd:0, dir:0, e:mk(3'd6, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[4] = '{gs:2'd1, mv:0, jp:0, up:1, dn:0, dd:0, dir:0, e:mk(3'd3, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[5] = '{gs:2'd1, mv:0, jp:0, up:1, dn:1, dd:0, dir:0, e:mk(3'd3, 3'd0, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{gs:2'd1, mv:0, jp:0, up:0, dn:1, dd:0, dir:0, e:mk(3'd4, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[7] = '{gs:2'd1, mv:0, jp:0, up:0, dn:0, dd:0, dir:0, e:mk(3'd0, 3'd0, 1'b0, 1'b1, 1'b0)};
        tbl[8] = '{gs:2'd1, mv:0, jp:0, up:0, dn:0, dd:0, dir:1, e:mk(3'd0, 3'd0, 1'b1, 1'b0, 1'b0)};
        tbl[9] = '{gs:2'd1, mv:1, jp:0, up:0, dn:0, dd:0, dir:1, e:mk(3'd1, 3'd0, 1'b1, 1'b1, 1'b0)};

        Reset     = 1'b1;
        frame_clk = 1'b0;
        set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); frame_clk = ~frame_clk;
            expect_cycle("reset_hold", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
        end
        @(negedge Clk); Reset = 1'b0; frame_clk = 1'b0;
        set_in(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle("reset_release", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));

        // RUN entry then a full 36-tick loop.
        set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_tick("run_entry", mk(3'd1, 3'd0, 1'b0, 1'b1, 1'b0));
        for (int j = 1; j <= 36; j++) begin
            do_tick("run_step", mk(3'd1, 3'((j / 6) % 6), 1'b0, 1'b0, 1'b0));
        end

        for (int v = 0; v < 10; v++) begin
            set_in(tbl[v].gs, tbl[v].mv, tbl[v].jp, tbl[v].up, tbl[v].dn, tbl[v].dd, tbl[v].dir);
            do_tick($sformatf("prio_%0d", v), tbl[v].e);
        end

        // Bring RUN to frameIdx 3, then die.
        for (int j = 1; j <= 18; j++) begin
            do_tick("run_to_3", mk(3'd1, 3'(j / 6), 1'b1, 1'b0, 1'b0));
        end
        set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_tick("dead_entry", mk(3'd7, 3'd0, 1'b1, 1'b1, 1'b0));
        for (int j = 1; j <= 32; j++) begin
            set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, (j < 12) ? 1'b1 : 1'b0, 1'(j % 2));
            do_tick("dead_step", mk(3'd7, (j / 6 > 4) ? 3'd4 : 3'(j / 6), 1'b1, 1'b0,
                                    (j == 24) ? 1'b1 : 1'b0));
        end

        // Leaving PLAY exits DEAD immediately without a tick.
        @(negedge Clk);
        u_if.gameState = 2'd2;
        expect_cycle("notplay_force", mk(3'd0, 3'd0, 1'b1, 1'b1, 1'b0));
        expect_cycle("notplay_hold", mk(3'd0, 3'd0, 1'b1, 1'b0, 1'b0));

        set_in(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_tick("run_reentry", mk(3'd1, 3'd0, 1'b0, 1'b1, 1'b0));
        for (int j = 1; j <= 5; j++) begin
            do_tick("pre_hold", mk(3'd1, 3'd0, 1'b0, 1'b0, 1'b0));
        end

        // frame_clk held high: only its first Clk counts as a tick.
        @(negedge Clk); frame_clk = 1'b1;
        repeat (100) @(posedge Clk);
        #1;
        exp_q.push_back(mk(3'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        check_out("held_high");
        @(negedge Clk); frame_clk = 1'b0;
        @(posedge Clk); #1;
        for (int j = 1; j <= 5; j++) begin
            do_tick("post_hold", mk(3'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        end
        do_tick("post_hold_adv", mk(3'd1, 3'd2, 1'b0, 1'b0, 1'b0));

        // Reset coinciding with a tick.
        @(negedge Clk); frame_clk = 1'b1; Reset = 1'b1;
        expect_cycle("reset_on_tick", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
        @(negedge Clk); frame_clk = 1'b0; Reset = 1'b0;
        expect_cycle("after_reset", mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
        do_tick("recover_run", mk(3'd1, 3'd0, 1'b0, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
